// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the synchronous UART transmitter.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  localparam logic IdleLevel = 1'b1;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: pulses tick on the last cycle of each CLKS_PER_BIT window while enabled.
module baud_tick_gen
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = cnt_width(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CntMax);

  // Held at zero while disabled so every frame starts phase-aligned to its accept edge.
  always_comb begin
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_sync.sv
// UART transmitter: start bit, DATA_W payload bits LSB first, one stop bit; all outputs registered.
module uart_tx_sync
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy
);

  localparam int unsigned BitCntW = cnt_width(DATA_W);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_W - 1);

  tx_state_e           state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic                tx_out_q, tx_out_d;
  logic                ready_q, ready_d;
  logic                busy_q;
  logic                tick_en;
  logic                tick;

  assign tick_en = (state_q != StIdle);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (tick_en),
    .tick(tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_out_d  = tx_out_q;
    ready_d   = ready_q;
    unique case (state_q)
      StIdle: begin
        tx_out_d = IdleLevel;
        if (tx_valid && ready_q) begin
          shift_d   = tx_data;
          bit_cnt_d = '0;
          tx_out_d  = ~IdleLevel;
          ready_d   = 1'b0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          tx_out_d  = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (tick) begin
          if (bit_cnt_q == LastBit) begin
            tx_out_d = IdleLevel;
            state_d  = StStop;
          end else begin
            tx_out_d  = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end
        end
      end
      StStop: begin
        if (tick) begin
          ready_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_out_q  <= IdleLevel;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_out_q  <= tx_out_d;
      ready_q   <= ready_d;
      busy_q    <= ~ready_d;
    end
  end

  assign tx_ready = ready_q;
  assign tx_out   = tx_out_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_sync.sv
// Self-checking bench for uart_tx_sync: scoreboarded frames at 4 clocks/bit plus a 1 clock/bit case.
module tb_uart_tx_sync;

  localparam int Cpb         = 4;
  localparam int FrameCycles = 10 * Cpb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_out;
  logic       busy;

  logic [7:0] tx_data1;
  logic       tx_valid1;
  logic       tx_ready1;
  logic       tx_out1;
  logic       busy1;

  uart_tx_sync #(
    .DATA_W      (8),
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_out  (tx_out),
    .busy    (busy)
  );

  uart_tx_sync #(
    .DATA_W      (8),
    .CLKS_PER_BIT(1)
  ) dut_cpb1 (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data1),
    .tx_valid(tx_valid1),
    .tx_ready(tx_ready1),
    .tx_out  (tx_out1),
    .busy    (busy1)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       gap_chk;
    logic [7:0] gap;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where tx_ready is seen high again.
  task automatic send(input logic [7:0] d, input bit hold, input bit gap_chk, input bit mid_en,
                      input logic [7:0] mid_d, output int waited);
    int n;
    int bad;
    sb_item_t it;
    tx_data  = d;
    tx_valid = 1'b1;
    waited   = 0;
    while (!tx_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!tx_ready) begin
      check_eq("accept_timeout", 32'(tx_ready), 32'd1);
      tx_valid = 1'b0;
      return;
    end
    it.data    = d;
    it.gap_chk = gap_chk;
    it.gap     = 8'(Cpb + 1);
    sb_q.push_back(it);
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
    n   = 0;
    bad = 0;
    forever begin
      @(negedge clk);
      if (busy === tx_ready) bad++;
      if (tx_ready || n >= 200) break;
      n++;
      if (mid_en && n == 12) tx_data = mid_d;
    end
    check_eq("ready_low_cycles", n, FrameCycles);
    check_eq("busy_inverse", bad, 0);
  endtask

  // Frame monitor: captures each frame sample-by-sample and checks it against the scoreboard.
  initial begin : mon
    logic       prev;
    int         high_run;
    int         gap;
    int         bad;
    int         ones;
    bit         abort;
    logic       s[FrameCycles];
    logic [7:0] d;
    sb_item_t   it;
    prev     = 1'b1;
    high_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev     = 1'b1;
        high_run = 0;
      end else if (prev && (tx_out === 1'b0)) begin
        gap   = high_run;
        s[0]  = tx_out;
        abort = 1'b0;
        for (int k = 1; k < FrameCycles; k++) begin
          @(negedge clk);
          if (rst) begin
            abort = 1'b1;
            break;
          end
          s[k] = tx_out;
        end
        prev     = 1'b1;
        high_run = 0;
        if (!abort) begin
          bad = 0;
          for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < Cpb; j++) begin
              if (s[b*Cpb+j] !== s[b*Cpb]) bad++;
            end
          end
          for (int i = 0; i < 8; i++) d[i] = s[(i+1)*Cpb];
          ones = 0;
          for (int k = FrameCycles - 1; k >= 0 && s[k] === 1'b1; k--) ones++;
          check_eq("bit_hold", bad, 0);
          check_eq("stop_bit", 32'(s[FrameCycles-1]), 32'd1);
          check_eq("frame_expected", 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check_eq("frame_data", d, it.data);
            if (it.gap_chk) check_eq("idle_gap", gap, it.gap);
          end
          high_run = ones;
          prev     = s[FrameCycles-1];
        end
      end else begin
        prev     = tx_out;
        high_run = (tx_out === 1'b1) ? high_run + 1 : 0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int         waited;
    int         lows;
    logic [7:0] c1;
    logic [9:0] exp1;
    logic [9:0] got1;
    logic [9:0] rdy1;
    logic       rdy1_after;

    rst       = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    tx_valid1 = 1'b0;
    tx_data1  = 8'h00;
    @(posedge clk);
    #1;
    check_eq("rst_tx_out", 32'(tx_out), 32'd1);
    check_eq("rst_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready_cpb1", 32'(tx_ready1), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);

    send(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, waited);
    check_eq("first_accept_wait", waited, 0);
    repeat (3) @(negedge clk);

    // Held offer with data changing mid-frame, then a back-to-back second offer.
    send(8'h3C, 1'b1, 1'b0, 1'b1, 8'hFF, waited);
    send(8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, waited);
    check_eq("held_offer_wait", waited, 0);
    repeat (3) @(negedge clk);

    send(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, waited);
    send(8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, waited);
    repeat (3) @(negedge clk);

    // Reset during data bit 3 of an unscoreboarded frame.
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check_eq("bit3_before_rst", 32'(tx_out), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_tx_out", 32'(tx_out), 32'd1);
    check_eq("midrst_ready", 32'(tx_ready), 32'd1);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    rst  = 1'b0;
    lows = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      tx_data = 8'($urandom);
      if (tx_out !== 1'b1) lows++;
    end
    check_eq("idle_line_high", lows, 0);
    send(8'h96, 1'b0, 1'b0, 1'b0, 8'h00, waited);
    check_eq("post_rst_accept_wait", waited, 0);

    // One clock per bit.
    c1 = 8'h81;
    @(negedge clk);
    tx_data1  = c1;
    tx_valid1 = 1'b1;
    @(posedge clk);
    #1;
    tx_valid1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      got1[k] = tx_out1;
      rdy1[k] = tx_ready1;
    end
    @(negedge clk);
    rdy1_after = tx_ready1;
    exp1[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp1[i+1] = c1[i];
    exp1[9] = 1'b1;
    check_eq("cpb1_frame", got1, exp1);
    check_eq("cpb1_ready_low", rdy1, 32'd0);
    check_eq("cpb1_ready_back", 32'(rdy1_after), 32'd1);

    repeat (5) @(negedge clk);
    check_eq("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
